// File: rtl/decode_pipe.sv
// Registered, handshaked decode stage for the A/B accumulator core: decode, branch resolve,
// flag interlock and wrong-path squash. Optional RELATIVE_BRANCH_EN makes branch targets PC-relative.
module decode_pipe #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned BR_OFF_W     = 7,
  parameter int unsigned FLAG_LAT     = 1,
  parameter int unsigned SQUASH_SLOTS = 1
) (
  input  logic              wClock,
  input  logic              wReset_n,
  input  logic [15:0]       wInstr,
  input  logic              wValid,
  output logic              rReady,
  input  logic [ADDR_W-1:0] wPc,
  input  logic              wZa,
  input  logic              wCa,
  input  logic              wNa,
  input  logic              wZb,
  input  logic              wCb,
  input  logic              wNb,
  input  logic              wReady,
  output logic              rValid,
  output logic              rBranchTaken,
  output logic              rJumpTaken,
  output logic [ADDR_W-1:0] rTargetPc,
  output logic [DATA_W-1:0] rImm,
  output logic              rMuxASel,
  output logic              rMuxBSel,
  output logic              rFlush
);

  localparam int unsigned CNT_W = (FLAG_LAT > 0) ? $clog2(FLAG_LAT + 1) : 1;
  localparam int unsigned SQ_W  = (SQUASH_SLOTS > 0) ? $clog2(SQUASH_SLOTS + 1) : 1;

  // Opcode map, instruction[15:10]
  localparam logic [5:0] OP_LDA   = 6'h01;
  localparam logic [5:0] OP_ADDA  = 6'h02;
  localparam logic [5:0] OP_SUBA  = 6'h03;
  localparam logic [5:0] OP_ANDA  = 6'h04;
  localparam logic [5:0] OP_ORA   = 6'h05;
  localparam logic [5:0] OP_ASLA  = 6'h06;
  localparam logic [5:0] OP_ASRA  = 6'h07;
  localparam logic [5:0] OP_LDB   = 6'h08;
  localparam logic [5:0] OP_ADDB  = 6'h09;
  localparam logic [5:0] OP_SUBB  = 6'h0A;
  localparam logic [5:0] OP_ANDB  = 6'h0B;
  localparam logic [5:0] OP_ORB   = 6'h0C;
  localparam logic [5:0] OP_ASLB  = 6'h0D;
  localparam logic [5:0] OP_ASRB  = 6'h0E;
  localparam logic [5:0] OP_LDCA  = 6'h10;
  localparam logic [5:0] OP_ADDCA = 6'h11;
  localparam logic [5:0] OP_SUBCA = 6'h12;
  localparam logic [5:0] OP_ANDCA = 6'h13;
  localparam logic [5:0] OP_ORCA  = 6'h14;
  localparam logic [5:0] OP_LDCB  = 6'h18;
  localparam logic [5:0] OP_ADDCB = 6'h19;
  localparam logic [5:0] OP_SUBCB = 6'h1A;
  localparam logic [5:0] OP_ANDCB = 6'h1B;
  localparam logic [5:0] OP_ORCB  = 6'h1C;
  localparam logic [5:0] OP_JMP   = 6'h20;
  localparam logic [5:0] OP_BAEQ  = 6'h28;
  localparam logic [5:0] OP_BANE  = 6'h29;
  localparam logic [5:0] OP_BACS  = 6'h2A;
  localparam logic [5:0] OP_BACC  = 6'h2B;
  localparam logic [5:0] OP_BAMI  = 6'h2C;
  localparam logic [5:0] OP_BAPL  = 6'h2D;
  localparam logic [5:0] OP_BBEQ  = 6'h30;
  localparam logic [5:0] OP_BBNE  = 6'h31;
  localparam logic [5:0] OP_BBCS  = 6'h32;
  localparam logic [5:0] OP_BBCC  = 6'h33;
  localparam logic [5:0] OP_BBMI  = 6'h34;
  localparam logic [5:0] OP_BBPL  = 6'h35;

  logic [5:0]          opcode;
  logic                isAOp, isBOp, isBrA, isBrB, isJmp, selA, selB, condTrue;
  logic                brTaken, redirect;
  logic [CNT_W-1:0]    cntA, cntB;
  logic [SQ_W-1:0]     sqCnt;
  logic                squashing, hazard, advance, accept, keep;
  logic [ADDR_W-1:0]   brTarget, nextTarget;
  logic signed [BR_OFF_W-1:0] brOff;

  assign opcode = wInstr[15:10];
  assign brOff  = wInstr[BR_OFF_W-1:0];

  // Opcode classification and flag condition
  always_comb begin
    isAOp    = 1'b0;
    isBOp    = 1'b0;
    isBrA    = 1'b0;
    isBrB    = 1'b0;
    isJmp    = 1'b0;
    selA     = 1'b0;
    selB     = 1'b0;
    condTrue = 1'b0;
    unique case (opcode)
      OP_LDA, OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA, OP_ASLA, OP_ASRA: isAOp = 1'b1;
      OP_LDB, OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB, OP_ASLB, OP_ASRB: isBOp = 1'b1;
      OP_LDCA:                              begin isAOp = 1'b1; selA = 1'b1; end
      OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA: begin isAOp = 1'b1; selB = 1'b1; end
      OP_LDCB:                              begin isBOp = 1'b1; selB = 1'b1; end
      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB: begin isBOp = 1'b1; selA = 1'b1; end
      OP_JMP:  isJmp = 1'b1;
      OP_BAEQ: begin isBrA = 1'b1; condTrue = wZa;  end
      OP_BANE: begin isBrA = 1'b1; condTrue = !wZa; end
      OP_BACS: begin isBrA = 1'b1; condTrue = wCa;  end
      OP_BACC: begin isBrA = 1'b1; condTrue = !wCa; end
      OP_BAMI: begin isBrA = 1'b1; condTrue = wNa;  end
      OP_BAPL: begin isBrA = 1'b1; condTrue = !wNa; end
      OP_BBEQ: begin isBrB = 1'b1; condTrue = wZb;  end
      OP_BBNE: begin isBrB = 1'b1; condTrue = !wZb; end
      OP_BBCS: begin isBrB = 1'b1; condTrue = wCb;  end
      OP_BBCC: begin isBrB = 1'b1; condTrue = !wCb; end
      OP_BBMI: begin isBrB = 1'b1; condTrue = wNb;  end
      OP_BBPL: begin isBrB = 1'b1; condTrue = !wNb; end
      default: ;
    endcase
  end

`ifdef RELATIVE_BRANCH_EN
  assign brTarget = wPc + ADDR_W'(brOff);
`else
  logic unusedPc;
  assign unusedPc = ^wPc;
  assign brTarget = ADDR_W'($unsigned(brOff));
`endif

  assign brTaken    = (isBrA | isBrB) & condTrue;
  assign redirect   = brTaken | isJmp;
  assign nextTarget = isJmp ? ADDR_W'(wInstr[9:0]) : (brTaken ? brTarget : '0);

  assign squashing = (sqCnt != '0);
  assign hazard    = wValid & ((isBrA & (cntA != '0)) | (isBrB & (cntB != '0)));
  assign advance   = !rValid | wReady;
  assign rReady    = wReset_n & advance & !hazard;
  assign accept    = wValid & rReady;
  assign keep      = accept & !squashing;

  // Flag scoreboard and wrong-path squash counter
  always_ff @(posedge wClock or negedge wReset_n) begin
    if (!wReset_n) begin
      cntA  <= '0;
      cntB  <= '0;
      sqCnt <= '0;
    end else begin
      if (keep & isAOp)      cntA <= CNT_W'(FLAG_LAT);
      else if (cntA != '0)   cntA <= cntA - CNT_W'(1);
      if (keep & isBOp)      cntB <= CNT_W'(FLAG_LAT);
      else if (cntB != '0)   cntB <= cntB - CNT_W'(1);
      if (accept & squashing)     sqCnt <= sqCnt - SQ_W'(1);
      else if (keep & redirect)   sqCnt <= SQ_W'(SQUASH_SLOTS);
    end
  end

  // Output register; holds while execute stalls, otherwise loads the decode or clears
  always_ff @(posedge wClock or negedge wReset_n) begin
    if (!wReset_n) begin
      rValid       <= 1'b0;
      rBranchTaken <= 1'b0;
      rJumpTaken   <= 1'b0;
      rTargetPc    <= '0;
      rImm         <= '0;
      rMuxASel     <= 1'b0;
      rMuxBSel     <= 1'b0;
      rFlush       <= 1'b0;
    end else begin
      rFlush <= keep & redirect;
      if (advance) begin
        rValid       <= keep;
        rBranchTaken <= keep & brTaken;
        rJumpTaken   <= keep & isJmp;
        rTargetPc    <= keep ? nextTarget : '0;
        rImm         <= (keep & (selA | selB)) ? DATA_W'(wInstr[7:0]) : '0;
        rMuxASel     <= keep & selA;
        rMuxBSel     <= keep & selB;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed testbench for decode_pipe; expected values hand-computed. RELATIVE_BRANCH_EN selects target expectations.
module tb_decode_pipe;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 10;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_LDA  = 6'h01;
  localparam logic [5:0] OP_ADDA = 6'h02;
  localparam logic [5:0] OP_LDB  = 6'h08;
  localparam logic [5:0] OP_LDCA = 6'h10;
  localparam logic [5:0] OP_LDCB = 6'h18;
  localparam logic [5:0] OP_ORCB = 6'h1C;
  localparam logic [5:0] OP_JMP  = 6'h20;
  localparam logic [5:0] OP_BAEQ = 6'h28;
  localparam logic [5:0] OP_BANE = 6'h29;
  localparam logic [5:0] OP_BBNE = 6'h31;
  localparam logic [5:0] OP_BAD  = 6'h3F;

  logic              wClock = 1'b0;
  logic              wReset_n;
  logic [15:0]       wInstr;
  logic              wValid;
  logic              rReady;
  logic [ADDR_W-1:0] wPc;
  logic              wZa, wCa, wNa, wZb, wCb, wNb;
  logic              wReady;
  logic              rValid, rBranchTaken, rJumpTaken;
  logic [ADDR_W-1:0] rTargetPc;
  logic [DATA_W-1:0] rImm;
  logic              rMuxASel, rMuxBSel, rFlush;

  int nChecks = 0;
  int nPassed = 0;

  decode_pipe dut (
    .wClock(wClock), .wReset_n(wReset_n), .wInstr(wInstr), .wValid(wValid), .rReady(rReady),
    .wPc(wPc), .wZa(wZa), .wCa(wCa), .wNa(wNa), .wZb(wZb), .wCb(wCb), .wNb(wNb),
    .wReady(wReady), .rValid(rValid), .rBranchTaken(rBranchTaken), .rJumpTaken(rJumpTaken),
    .rTargetPc(rTargetPc), .rImm(rImm), .rMuxASel(rMuxASel), .rMuxBSel(rMuxBSel), .rFlush(rFlush)
  );

  always #5 wClock = ~wClock;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPassed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [9:0] low);
    return {op, low};
  endfunction

  task automatic cyc();
    @(posedge wClock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins);
    wValid = v;
    wInstr = ins;
    #1;
  endtask

  logic [ADDR_W-1:0] expRel1, expRel2;

  initial begin
`ifdef RELATIVE_BRANCH_EN
    expRel1 = 10'h00E;
    expRel2 = 10'h3FE;
`else
    expRel1 = 10'h07E;
    expRel2 = 10'h07D;
`endif
    wReset_n = 1'b0; wInstr = '0; wValid = 1'b0; wPc = '0; wReady = 1'b1;
    wZa = 0; wCa = 0; wNa = 0; wZb = 0; wCb = 0; wNb = 0;
    repeat (2) cyc();
    checkEq("rst_valid", 32'(rValid), 0);
    checkEq("rst_ready", 32'(rReady), 0);
    checkEq("rst_flush", 32'(rFlush), 0);
    checkEq("rst_imm",   32'(rImm),   0);
    wReset_n = 1'b1;
    #1;
    checkEq("idle_ready", 32'(rReady), 1);

    // Constant load into A side
    drive(1, mk(OP_LDCA, 10'h05A));
    cyc();
    drive(0, '0);
    checkEq("ldca_valid", 32'(rValid), 1);
    checkEq("ldca_muxa",  32'(rMuxASel), 1);
    checkEq("ldca_muxb",  32'(rMuxBSel), 0);
    checkEq("ldca_imm",   32'(rImm), 32'h5A);
    checkEq("ldca_br",    32'(rBranchTaken), 0);
    checkEq("ldca_jmp",   32'(rJumpTaken), 0);
    cyc();
    checkEq("drain_valid", 32'(rValid), 0);

    // Flag interlock: ADDA then BAEQ
    wZa = 1'b1;
    drive(1, mk(OP_ADDA, 10'h000));
    cyc();
    drive(1, mk(OP_BAEQ, 10'h025));
    checkEq("haz_ready0", 32'(rReady), 0);
    checkEq("haz_adda_valid", 32'(rValid), 1);
    cyc();
    checkEq("haz_ready1", 32'(rReady), 1);
    checkEq("haz_bubble", 32'(rValid), 0);
    cyc();
    drive(0, '0);
    checkEq("baeq_valid",  32'(rValid), 1);
    checkEq("baeq_taken",  32'(rBranchTaken), 1);
    checkEq("baeq_target", 32'(rTargetPc), 32'h025);
    checkEq("baeq_flush",  32'(rFlush), 1);
    checkEq("baeq_jmp",    32'(rJumpTaken), 0);
    cyc();
    checkEq("baeq_flush_off", 32'(rFlush), 0);
    drive(1, mk(OP_LDB, 10'h000));
    cyc();
    drive(0, '0);
    checkEq("baeq_squash", 32'(rValid), 0);
    wZa = 1'b0;

    // Jump with squash of the following instruction
    drive(1, mk(OP_JMP, 10'h3FF));
    cyc();
    drive(1, mk(OP_LDCB, 10'h011));
    checkEq("jmp_taken",  32'(rJumpTaken), 1);
    checkEq("jmp_target", 32'(rTargetPc), 32'h3FF);
    checkEq("jmp_flush",  32'(rFlush), 1);
    checkEq("jmp_br",     32'(rBranchTaken), 0);
    checkEq("jmp_ready",  32'(rReady), 1);
    cyc();
    drive(1, mk(OP_LDB, 10'h000));
    checkEq("ldcb_dropped", 32'(rValid), 0);
    checkEq("jmp_flush_off", 32'(rFlush), 0);
    cyc();
    drive(0, '0);
    checkEq("ldb_valid",  32'(rValid), 1);
    checkEq("ldb_jmp",    32'(rJumpTaken), 0);
    checkEq("ldb_target", 32'(rTargetPc), 0);
    checkEq("ldb_imm",    32'(rImm), 0);
    checkEq("ldb_muxb",   32'(rMuxBSel), 0);
    cyc();

    // Backpressure holds ORCB for three cycles
    drive(1, mk(OP_ORCB, 10'h00F));
    cyc();
    wReady = 1'b0;
    drive(1, mk(OP_LDA, 10'h000));
    for (int i = 0; i < 3; i++) begin
      checkEq("bp_valid", 32'(rValid), 1);
      checkEq("bp_muxa",  32'(rMuxASel), 1);
      checkEq("bp_imm",   32'(rImm), 32'h0F);
      checkEq("bp_ready", 32'(rReady), 0);
      cyc();
    end
    wReady = 1'b1;
    #1;
    checkEq("bp_release_ready", 32'(rReady), 1);
    cyc();
    drive(0, '0);
    checkEq("bp_lda_valid", 32'(rValid), 1);
    checkEq("bp_lda_muxa",  32'(rMuxASel), 0);
    checkEq("bp_lda_imm",   32'(rImm), 0);
    cyc();

    // Not-taken branch, no squash; then unknown opcode
    wZb = 1'b1;
    drive(1, mk(OP_BBNE, 10'h033));
    cyc();
    drive(1, mk(OP_LDA, 10'h000));
    checkEq("bbne_valid",  32'(rValid), 1);
    checkEq("bbne_taken",  32'(rBranchTaken), 0);
    checkEq("bbne_target", 32'(rTargetPc), 0);
    checkEq("bbne_flush",  32'(rFlush), 0);
    cyc();
    drive(1, mk(OP_BAD, 10'h3FF));
    checkEq("nosquash_valid", 32'(rValid), 1);
    cyc();
    drive(0, '0);
    checkEq("bad_valid",  32'(rValid), 1);
    checkEq("bad_imm",    32'(rImm), 0);
    checkEq("bad_muxa",   32'(rMuxASel), 0);
    checkEq("bad_muxb",   32'(rMuxBSel), 0);
    checkEq("bad_jmp",    32'(rJumpTaken), 0);
    checkEq("bad_target", 32'(rTargetPc), 0);
    cyc();
    wZb = 1'b0;

    // Branch target forms (relative with wrap, or absolute)
    wPc = 10'h010;
    drive(1, mk(OP_BANE, 10'h07E));
    cyc();
    drive(1, mk(OP_NOP, 10'h000));
    checkEq("rel1_taken",  32'(rBranchTaken), 1);
    checkEq("rel1_target", 32'(rTargetPc), 32'(expRel1));
    cyc();
    wPc = 10'h001;
    drive(1, mk(OP_BANE, 10'h07D));
    cyc();
    drive(1, mk(OP_NOP, 10'h000));
    checkEq("rel2_target", 32'(rTargetPc), 32'(expRel2));
    cyc();
    drive(0, '0);
    wPc = '0;
    cyc();

    // Asynchronous reset while holding a JMP with squash pending
    drive(1, mk(OP_JMP, 10'h155));
    cyc();
    wReady = 1'b0;
    drive(0, '0);
    checkEq("hold_jmp", 32'(rJumpTaken), 1);
    #2;
    wReset_n = 1'b0;
    #1;
    checkEq("arst_valid",  32'(rValid), 0);
    checkEq("arst_jmp",    32'(rJumpTaken), 0);
    checkEq("arst_target", 32'(rTargetPc), 0);
    checkEq("arst_flush",  32'(rFlush), 0);
    checkEq("arst_ready",  32'(rReady), 0);
    cyc();
    cyc();
    wReset_n = 1'b1;
    wReady = 1'b1;
    drive(1, mk(OP_LDA, 10'h000));
    cyc();
    drive(0, '0);
    checkEq("post_rst_valid",  32'(rValid), 1);
    checkEq("post_rst_jmp",    32'(rJumpTaken), 0);
    checkEq("post_rst_target", 32'(rTargetPc), 0);
    checkEq("post_rst_imm",    32'(rImm), 0);
    checkEq("post_rst_flush",  32'(rFlush), 0);
    cyc();

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Registered, handshaked instruction decode stage for the two-accumulator (A/B) 8-bit core.
- Sits between fetch and execute.
- Decodes each 16-bit instruction against the shared opcode macros: LDA..ASRA, LDCA..ORCB, JMP, BAEQ..BBPL.
- Resolves branches and jumps, and holds A-/B-flag branches while flag-writing ops are still in flight.
- After a taken branch or jump, squashes the wrong-path instructions already fetched.

Parameters:
- DATA_W, 8: width of the immediate/constant output. Constant is instruction[7:0], zero-extended if DATA_W>8.
- ADDR_W, 10: program address width. Targets are zero-extended (or truncated) to this width.
- BR_OFF_W, 7: width of the branch offset field, instruction[BR_OFF_W-1:0].
- FLAG_LAT, 1: cycles after issue of a flag-writing op before wZa/wCa/wNa (or wZb/wCb/wNb) are valid. 0 disables the interlock.
- SQUASH_SLOTS, 1: number of accepted instructions dropped after a taken branch or jump.

Ports:
- wClock  in  1  clock, rising edge
- wReset_n  in  1  asynchronous active-low reset
- wInstr  in  16  instruction from fetch
- wValid  in  1  wInstr valid
- rReady  out  1  stage accepts wInstr this cycle
- wPc  in  ADDR_W  address of wInstr. Used only with RELATIVE_BRANCH_EN.
- wZa, wCa, wNa, wZb, wCb, wNb  in  1 each  flags from execute
- wReady  in  1  execute accepts output this cycle
- rValid  out  1  output register holds a decoded instruction
- rBranchTaken  out  1  conditional branch taken
- rJumpTaken  out  1  JMP
- rTargetPc  out  ADDR_W  branch/jump target
- rImm  out  DATA_W  constant operand
- rMuxASel  out  1  A-side constant select
- rMuxBSel  out  1  B-side constant select
- rFlush  out  1  one-cycle pulse to fetch on taken branch or jump issue

Behaviour:
- Reset (asynchronous, while wReset_n=0): all registered outputs 0, squash counter 0, both scoreboard counters 0, rReady=0.
- Handshake:
  - accept = wValid & rReady.
  - rReady = wReset_n & (!rValid | wReady) & !hazard.
  - When rValid & !wReady, every output holds its value.
  - rValid is set on accept (unless squashed). It is cleared when wReady=1 and nothing new is accepted.
- Latency: 1 cycle from accept to rValid.
- Decode into the output register:
  - LDCA/ADDCB/SUBCB/ANDCB/ORCB: rMuxASel=1.
  - LDCB/ADDCA/SUBCA/ANDCA/ORCA: rMuxBSel=1.
  - For all constant ops: rImm = instruction[7:0].
  - All other ops: rImm=0 and both selects 0.
  - JMP: rJumpTaken=1, rTargetPc = instruction[9:0].
  - Bxxx: flag condition evaluated on the accept cycle.
    - Taken: rBranchTaken=1, rTargetPc = instruction[BR_OFF_W-1:0].
    - Not taken: rTargetPc=0.
  - Unknown opcode: decodes as a NOP with rValid=1 and all other outputs 0.
- Flag scoreboard: two counters, cntA and cntB.
  - On accept of an op targeting A (LDA, ADDA, SUBA, ANDA, ORA, ASLA, ASRA and the *CA ops), cntA loads FLAG_LAT. B-targeting ops load cntB the same way.
  - Otherwise each counter decrements once per cycle, saturating at 0. A load takes priority over a decrement in the same cycle.
  - hazard = (incoming BA** and cntA!=0) | (incoming BB** and cntB!=0).
- Flush/squash:
  - On the issue cycle of a taken branch or JMP, rFlush=1 on the following cycle for exactly one cycle.
  - The squash counter loads SQUASH_SLOTS.
  - While the squash counter !=0, accepted instructions decrement it and are discarded: no rValid, no scoreboard update.
  - A taken branch arriving while squashing is itself discarded.
- Reset mid-operation: the pending squash and scoreboard state are lost, and the next instruction after release decodes normally.

Optional Feature:
- Macro: RELATIVE_BRANCH_EN.
- Defined: conditional branch target = wPc + sign-extended instruction[BR_OFF_W-1:0], modulo 2^ADDR_W (wrap-around). JMP stays absolute.
- Undefined: branch target = zero-extended offset (absolute), and wPc is ignored and may be left tied to 0.

Test Plan:
- Reset: with rValid=1 holding JMP state, drive wReset_n=0 asynchronously → all outputs 0 before the next edge. Release, then LDA → rValid=1 one cycle later, all other outputs 0.
- LDCA 0x5A, wReady=1 → next cycle rValid=1, rMuxASel=1, rMuxBSel=0, rImm=0x5A, rBranchTaken=rJumpTaken=0.
- FLAG_LAT=1: ADDA then BAEQ back-to-back with wZa=1 → rReady=0 for exactly 1 cycle, then BAEQ issues with rBranchTaken=1, rTargetPc=offset, rFlush pulses once.
- JMP with instruction[9:0]=0x3FF, followed by LDCB 0x11 then LDB → rJumpTaken=1, rTargetPc=0x3FF. LDCB is dropped (no rValid). LDB issues normally.
- Backpressure: rValid=1 with ORCB 0x0F, wReady=0 for 3 cycles → outputs stable and rReady=0 throughout. When wReady=1, the next instruction is accepted the same cycle.
- RELATIVE_BRANCH_EN: wPc=0x010, BANE offset 0x7E (-2), wZa=0 → rTargetPc=0x00E. Then wPc=0x001, offset 0x7D (-3) → rTargetPc=0x3FE (wrap).
